// File: rtl/pe_ctx_issuer.sv
// pe_ctx_issuer: steps through a per-PE context memory, issuing FU ops and returning results on valid/ready.
module pe_ctx_issuer #(
  parameter int FU_W      = 4,
  parameter int DATA_W    = 32,
  parameter int IMM_W     = 16,
  parameter int CTX_DEPTH = 16,
  parameter int AW        = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [AW-1:0]           cfg_addr,
  input  logic [FU_W+4+IMM_W-1:0] cfg_wdata,
  input  logic [AW:0]             cfg_len,
  input  logic [15:0]             cfg_iter,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_a,
  input  logic [DATA_W-1:0]       in_b,
  output logic                    in_ready,
  output logic [FU_W-1:0]         fu_opcode,
  output logic [DATA_W-1:0]       fu_a,
  output logic [DATA_W-1:0]       fu_b,
  input  logic [DATA_W-1:0]       fu_result,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int CW = FU_W + 4 + IMM_W;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     ctx_q [CTX_DEPTH];
  logic [CW-1:0]     ctx_d [CTX_DEPTH];
  logic [AW-1:0]     pc_q, pc_d;
  logic [AW:0]       len_q, len_d;
  logic [15:0]       pass_q, pass_d, iter_q, iter_d;
  logic [DATA_W-1:0] acc_q, acc_d, out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d, done_q, done_d, err_q, err_d;
  logic [CW-1:0]     cur;
  logic [FU_W-1:0]   op;
  logic [1:0]        sa, sb;
  logic [DATA_W-1:0] immx, res;
  logic              run, fire, wrap, last, illegal, start_ok;

  function automatic logic [DATA_W-1:0] sel(input logic [1:0] s, input logic [DATA_W-1:0] in, imm, acc);
    return s == 2'd0 ? in : s == 2'd1 ? imm : s == 2'd2 ? acc : '0;
  endfunction

  assign cur       = ctx_q[pc_q];
  assign op        = cur[CW-1 -: FU_W];
  assign sa        = cur[IMM_W+3 -: 2];
  assign sb        = cur[IMM_W+1 -: 2];
  assign immx      = DATA_W'(cur[IMM_W-1:0]);
  assign run       = state_q == RUN;
  assign in_ready  = run & (~out_valid_q | out_ready);
  assign fire      = in_valid & in_ready;
  assign wrap      = {1'b0, pc_q} == len_q - 1'b1;
  assign last      = wrap & (pass_q == iter_q - 16'd1);
  assign illegal   = op > FU_W'(8);
  assign res       = illegal ? '0 : fu_result;
  assign start_ok  = start && cfg_len != '0 && cfg_len <= (AW+1)'(CTX_DEPTH) && cfg_iter != '0;
  assign fu_opcode = run ? op : '0;
  assign fu_a      = run ? sel(sa, in_a, immx, acc_q) : '0;
  assign fu_b      = run ? sel(sb, in_b, immx, acc_q) : '0;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = state_q != IDLE;

  always_comb begin
    state_d     = state_q;
    ctx_d       = ctx_q;
    pc_d        = pc_q;
    pass_d      = pass_q;
    len_d       = len_q;
    iter_d      = iter_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~out_ready;
    done_d      = 1'b0;
    err_d       = err_q;
    if (state_q == IDLE && cfg_we) ctx_d[cfg_addr] = cfg_wdata;
    if (state_q == IDLE && start_ok) begin
      state_d = RUN;
      pc_d    = '0;
      pass_d  = '0;
      len_d   = cfg_len;
      iter_d  = cfg_iter;
    end
    // a fire in the same cycle as an accept reloads out_valid for full throughput
    if (fire) begin
      out_valid_d = 1'b1;
      out_data_d  = res;
      acc_d       = res;
      err_d       = err_q | illegal;
      pc_d        = wrap ? '0 : pc_q + 1'b1;
      pass_d      = wrap ? pass_q + 16'd1 : pass_q;
      state_d     = last ? DRAIN : state_q;
    end
    if (state_q == DRAIN && out_valid_q && out_ready) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ctx_q       <= '{default: '0};
      pc_q        <= '0;
      pass_q      <= '0;
      len_q       <= '0;
      iter_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctx_q       <= ctx_d;
      pc_q        <= pc_d;
      pass_q      <= pass_d;
      len_q       <= len_d;
      iter_q      <= iter_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: doc/pe_ctx_issuer.md
Name: pe_ctx_issuer

Overview:
- Per-PE context sequencer that drives the functional unit: holds a small context memory of FU instructions and steps through it.
- Each step selects operands, issues `fu_opcode`/`fu_a`/`fu_b`, captures `fu_result` and presents it on a valid/ready output.
- Sits between the PE input routing and the PE output register; it is the initiator side of the FU opcode/operand interface.

Parameters:
- FU_W, 4, opcode width; must match the FU opcode field.
- DATA_W, 32, operand/result width.
- IMM_W, 16, immediate field width.
- CTX_DEPTH, 16, context entries; power of two.
- AW, 4, log2(CTX_DEPTH).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  context write strobe.
- cfg_addr  in  AW  context write address.
- cfg_wdata  in  FU_W+4+IMM_W  {opcode, srca[1:0], srcb[1:0], imm}.
- cfg_len  in  AW+1  number of contexts per pass, 1..CTX_DEPTH.
- cfg_iter  in  16  number of passes.
- start  in  1  begin execution (sampled in IDLE).
- in_valid  in  1  input operand beat valid.
- in_a  in  DATA_W  routed operand A.
- in_b  in  DATA_W  routed operand B.
- in_ready  out  1  issuer accepts beat.
- fu_opcode  out  FU_W  opcode to FU.
- fu_a  out  DATA_W  FU operand A.
- fu_b  out  DATA_W  FU operand B.
- fu_result  in  DATA_W  combinational FU result.
- out_valid  out  1  result available.
- out_data  out  DATA_W  registered result.
- out_ready  in  1  downstream accepts result.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky: illegal opcode issued.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=0, pass counter=0, acc=0.
  - out_valid=0, out_data=0, done=0, err=0.
  - All context entries cleared to 0 (ADD, srca=srcb=0, imm=0).
- Opcode encoding (fixed): ADD=0, SUB=1, MULT=2, SLL=3, SRL=4, AND=5, OR=6, NOT=7, XOR=8. Values 9..15 are illegal.
- Context writes:
  - Accepted only in IDLE; cfg_we in RUN/DRAIN is ignored.
  - cfg_len and cfg_iter are sampled at start and held internally.
- Operand select, per srca/srcb:
  - 0 = in_a / in_b.
  - 1 = imm zero-extended to DATA_W.
  - 2 = acc (last issued result).
  - 3 = 0.
- Issue path is combinational from ctx[pc]: fu_opcode, fu_a, fu_b. In IDLE/DRAIN: fu_opcode=0, fu_a=fu_b=0.
- States:
  - IDLE: start=1 with cfg_len in 1..CTX_DEPTH and cfg_iter!=0 -> RUN, with pc=0 and pass=0. Any other start is ignored and the block stays IDLE.
  - RUN: in_ready = !out_valid | out_ready. Fire = in_valid & in_ready. Every context consumes exactly one input beat, even if it uses no input operand. On fire:
    - out_data <= fu_result; acc <= fu_result; out_valid <= 1.
    - Illegal opcode: out_data and acc are set to 0 instead, and err <= 1.
    - pc advances; after pc == cfg_len-1 it wraps to 0 and pass increments.
    - Fire on the last context of the last pass -> DRAIN.
  - DRAIN: in_ready=0. When out_valid & out_ready: out_valid <= 0, done <= 1 for one cycle, -> IDLE.
- out_valid clears on out_ready in any state unless a new fire in the same cycle reloads it. A simultaneous accept and fire keeps out_valid=1 with the new data (full throughput, 1 result/cycle).
- Latency: in-beat to out_valid is 1 cycle.
- out_data and out_valid stay stable while out_valid=1 & out_ready=0.
- acc persists across passes; it is reset only by rst_n.
- err clears only on reset.
- Reset asserted mid-RUN aborts immediately; no done pulse is produced.
- busy=1 in RUN and DRAIN.

Test Plan:
- Program ctx0 = {ADD, srca=0, srcb=1, imm=5}, cfg_len=1, cfg_iter=3, start.
  - Stimulus: in_a = 10, 20, 30 with out_ready=1.
  - Required: out_data = 15, 25, 35, each 1 cycle after its beat; done pulses 1 cycle after the third result.
- Accumulator chain: ctx0 = {ADD, srca=2, srcb=0}, len=1, iter=4, in_b = 1,2,3,4.
  - Required: out_data = 1, 3, 6, 10.
- Backpressure: hold out_ready=0 for 5 cycles after the first result.
  - Required: in_ready=0, out_data held, no beat lost; after release results continue in order.
- Multi-context wrap: ctx0 = MULT(in_a, imm=3), ctx1 = SUB(acc, imm=1), len=2, iter=2, in_a = 2, x, 4, x.
  - Required: 6, 5, 12, 11; pc wraps to 0.
- Illegal opcode 12 in ctx0, len=1, iter=1.
  - Required: out_data=0, err=1 stays high until reset; done still pulses.
- Boundary cases:
  - start with cfg_len=0 -> busy stays 0.
  - cfg_we during RUN -> context unchanged.
  - rst_n low mid-RUN -> all outputs 0 asynchronously, no done.
